// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser and per-key stability counter for board push-buttons,
// producing a clean level plus press/release strobes. Define KEY_AUTOREPEAT_EN for held-key repeat.
module key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_any
);

  localparam int                  CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_RAW = {NUM_KEYS{ACTIVE_LOW != 0}};

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  // Stage p0/p1: two-flop synchroniser; flops idle at the released pin value.
  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;
  logic [NUM_KEYS-1:0] norm_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE_RAW;
      sync_p1 <= IDLE_RAW;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // XOR with the idle pattern makes 1 mean pressed regardless of pin polarity.
  assign norm_p1 = sync_p1 ^ IDLE_RAW;

  // Stage p2: per-key stability counter, debounced level and registered strobes.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             deb_press;

    always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      deb_press = 1'b0;
      release_d = 1'b0;
      if (norm_p1[i] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d   = norm_p1[i];
          deb_press = norm_p1[i];
          release_d = ~norm_p1[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;
    logic            rph_q;
    logic            rph_d;
    logic            rep_d;

    // rph marks that the initial delay has elapsed and the shorter period now applies.
    always_comb begin
      rc_d  = '0;
      rph_d = 1'b0;
      rep_d = 1'b0;
      if (level_q && level_d) begin
        rph_d = rph_q;
        if (!rph_q && rc_q == RC_W'(REPEAT_DELAY - 1)) begin
          rep_d = 1'b1;
          rph_d = 1'b1;
        end else if (rph_q && rc_q == RC_W'(REPEAT_PERIOD - 1)) begin
          rep_d = 1'b1;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rc_q  <= '0;
        rph_q <= 1'b0;
      end else begin
        rc_q  <= rc_d;
        rph_q <= rph_d;
      end
    end

    assign press_d = deb_press | rep_d;
`else
    assign press_d = deb_press;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

  assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: reset, clean press, bounce, glitch/release, simultaneous keys,
// mid-operation reset and the press-strobe count on a long hold (auto-repeat aware).
module tb_key_debounce;

  localparam int DEB = 16;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_raw;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic       key_any;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS       (3),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (64),
    .REPEAT_PERIOD  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_any    (key_any)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {any, release, press, level}; any is derived from the expected level.
  task automatic chk_all(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                         input logic [2:0] rel);
    chk(tag, {22'd0, key_any, key_release, key_press, key_level},
             {22'd0, |lvl, rel, prs, lvl});
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  np;
    bit  found;
    logic exp_p;

    rst     = 1'b1;
    key_raw = 3'b111;
    repeat (3) tick();
    chk_all("reset_hold", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk_all("reset_idle", 3'b000, 3'b000, 3'b000);
    end

    // Clean press of KEY1: level rises on the 18th edge from the first sample.
    key_raw = 3'b101;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("press1_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("press1_edge", 3'b010, 3'b010, 3'b000);
    tick();
    chk_all("press1_after", 3'b010, 3'b000, 3'b000);

    // KEY0 bounces with 3-cycle runs, then settles pressed.
    for (int c = 0; c < 40; c++) begin
      key_raw[0] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk_all("bounce", 3'b010, 3'b000, 3'b000);
    end
    key_raw[0] = 1'b0;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("bounce_settle_wait", 3'b010, 3'b000, 3'b000);
    end
    tick();
    chk_all("bounce_press", 3'b011, 3'b001, 3'b000);
    tick();
    chk_all("bounce_after", 3'b011, 3'b000, 3'b000);

    // Press KEY2.
    key_raw[2] = 1'b0;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("press2_wait", 3'b011, 3'b000, 3'b000);
    end
    tick();
    chk_all("press2_edge", 3'b111, 3'b100, 3'b000);
    tick();
    chk_all("press2_after", 3'b111, 3'b000, 3'b000);

    // 15-cycle release glitch on KEY2 is one short of qualifying.
    key_raw[2] = 1'b1;
    for (int c = 0; c < DEB - 1; c++) begin
      tick();
      chk_all("glitch", 3'b111, 3'b000, 3'b000);
    end
    key_raw[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_all("glitch_tail", 3'b111, 3'b000, 3'b000);
    end

    // Real release of KEY2.
    key_raw[2] = 1'b1;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("release2_wait", 3'b111, 3'b000, 3'b000);
    end
    tick();
    chk_all("release2_edge", 3'b011, 3'b000, 3'b100);
    tick();
    chk_all("release2_after", 3'b011, 3'b000, 3'b000);

    // KEY0 and KEY1 released on the same edge.
    key_raw = 3'b111;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("release01_wait", 3'b011, 3'b000, 3'b000);
    end
    tick();
    chk_all("release01_edge", 3'b000, 3'b000, 3'b011);
    tick();
    chk_all("release01_after", 3'b000, 3'b000, 3'b000);

    // KEY0 and KEY2 pressed on the same edge.
    key_raw = 3'b010;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("press02_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("press02_edge", 3'b101, 3'b101, 3'b000);
    tick();
    chk_all("press02_after", 3'b101, 3'b000, 3'b000);

    key_raw = 3'b111;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("release02_wait", 3'b101, 3'b000, 3'b000);
    end
    tick();
    chk_all("release02_edge", 3'b000, 3'b000, 3'b101);
    tick();
    chk_all("release02_after", 3'b000, 3'b000, 3'b000);

    // Press KEY0+KEY2 again and reset when the counters sit at 10.
    key_raw = 3'b010;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_all("prereset_wait", 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b1;
    #1;
    chk_all("midreset_async", 3'b000, 3'b000, 3'b000);
    tick();
    tick();
    chk_all("midreset_hold", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int c = 1; c < DEB + 2; c++) begin
      tick();
      chk_all("requal_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("requal_edge", 3'b101, 3'b101, 3'b000);
    tick();
    chk_all("requal_after", 3'b101, 3'b000, 3'b000);

    key_raw = 3'b111;
    for (int c = 1; c < DEB + 2; c++) tick();
    tick();
    chk_all("release_all_edge", 3'b000, 3'b000, 3'b101);

    // Long hold of KEY1: one press strobe, plus repeats when auto-repeat is built in.
    key_raw = 3'b101;
    found   = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (key_press[1]) begin
        found = 1'b1;
        break;
      end
    end
    chk("hold_first_press", {31'd0, found}, 32'd1);
    np = found ? 1 : 0;
    for (int off = 1; off < 200; off++) begin
      tick();
      exp_p = AUTOREP && off >= 64 && ((off - 64) % 16 == 0);
      chk("hold_press_offset", {31'd0, key_press[1]}, {31'd0, exp_p});
      if (key_press[1]) np++;
    end
    chk("hold_press_count", np, AUTOREP ? 32'd10 : 32'd1);

    key_raw = 3'b111;
    found   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (key_release[1]) begin
        found = 1'b1;
        break;
      end
    end
    chk("hold_release_seen", {31'd0, found}, 32'd1);
    for (int c = 0; c < 30; c++) begin
      tick();
      chk_all("after_release", 3'b000, 3'b000, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
